// File: rtl/ship_move_pkg.sv
// Shared types, tuning constants and helpers for the player-ship motion controller.
// Widths are derived from FRAC_BITS so the position register never overflows across the screen.
package ship_move_pkg;

  typedef enum logic [0:0] {
    ST_ACTIVE = 1'b0,
    ST_HIT    = 1'b1
  } ship_state_t;

  localparam int INITIAL_X      = 280;
  localparam int INITIAL_Y      = 400;
  localparam int FRAC_BITS      = 6;
  localparam int MAX_SPEED      = 192;
  localparam int ACCEL          = 48;
  localparam int LEFT_BOUNDARY  = 5;
  localparam int RIGHT_BOUNDARY = 570;
  localparam int HIT_FRAMES     = 60;
  localparam int BLINK_FRAMES   = 4;

  localparam int POS_W   = 11 + FRAC_BITS + 1;
  localparam int VEL_W   = 12;
  localparam int CNT_W   = $clog2(HIT_FRAMES + 1);
  localparam int BLINK_W = $clog2(BLINK_FRAMES + 1);

  // Clip a one-bit-wider velocity sum back into +/-lim and the VEL_W output range.
  function automatic logic signed [VEL_W-1:0] sat_vel(
    input logic signed [VEL_W:0] v,
    input logic signed [VEL_W:0] lim
  );
    logic signed [VEL_W:0] neg_lim;
    logic signed [VEL_W:0] clipped;
    neg_lim = -lim;
    if (v > lim) begin
      clipped = lim;
    end else if (v < neg_lim) begin
      clipped = neg_lim;
    end else begin
      clipped = v;
    end
    return VEL_W'(clipped);
  endfunction

endpackage

// File: rtl/hit_blink_timer.sv
// Post-hit timer: counts HIT_FRAMES frames down and toggles the draw enable every BLINK_FRAMES frames.
// done is asserted combinationally on the frame tick that ends the hit window.
module hit_blink_timer
  import ship_move_pkg::*;
(
  input  logic clk,
  input  logic resetN,
  input  logic start,
  input  logic frameTick,
  output logic done,
  output logic visible
);

  logic [CNT_W-1:0]   r_hit_cnt;
  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_visible;

  assign done    = frameTick & (r_hit_cnt == CNT_W'(1));
  assign visible = r_visible;

  // Hit window countdown, blink phase counter and the registered draw enable.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_hit_cnt   <= {CNT_W{1'b0}};
      r_blink_cnt <= {BLINK_W{1'b0}};
      r_visible   <= 1'b1;
    end else if (start) begin
      r_hit_cnt   <= CNT_W'(HIT_FRAMES);
      r_blink_cnt <= {BLINK_W{1'b0}};
      r_visible   <= 1'b0;
    end else if (frameTick) begin
      if (done) begin
        r_hit_cnt   <= {CNT_W{1'b0}};
        r_blink_cnt <= {BLINK_W{1'b0}};
        r_visible   <= 1'b1;
      end else begin
        r_hit_cnt <= r_hit_cnt - CNT_W'(1);
        if (r_blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
          r_blink_cnt <= {BLINK_W{1'b0}};
          r_visible   <= ~r_visible;
        end else begin
          r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/ship_move_ctrl.sv
// Player-ship horizontal trajectory generator with hit/respawn handling.
// Define SHIP_MOVE_INERTIA_EN for accelerating/decelerating motion; otherwise keys give instant speed.
module ship_move_ctrl
  import ship_move_pkg::*;
(
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    startOfFrame,
  input  logic                    RightMove,
  input  logic                    LeftMove,
  input  logic                    hitPulse,
  output logic signed [10:0]      topLeftX,
  output logic signed [10:0]      topLeftY,
  output logic signed [VEL_W-1:0] velocityX,
  output logic                    inHit,
  output logic                    visible
);

  localparam logic signed [POS_W-1:0] INIT_POS   = POS_W'(INITIAL_X * (2 ** FRAC_BITS));
  localparam logic signed [POS_W-1:0] LEFT_POS   = POS_W'(LEFT_BOUNDARY * (2 ** FRAC_BITS));
  localparam logic signed [POS_W-1:0] RIGHT_POS  = POS_W'(RIGHT_BOUNDARY * (2 ** FRAC_BITS));
  localparam logic signed [10:0]      INIT_X_PIX = 11'(INITIAL_X);
  localparam logic signed [10:0]      INIT_Y_PIX = 11'(INITIAL_Y);

  ship_state_t             r_state;
  logic signed [POS_W-1:0] r_pos;
  logic signed [VEL_W-1:0] r_vel;
  logic signed [10:0]      r_top_left_x;
  logic signed [10:0]      r_top_left_y;
  logic                    r_in_hit;

  logic                    w_right;
  logic                    w_left;
  logic signed [VEL_W-1:0] w_vel_next;
  logic signed [POS_W-1:0] w_pos_sum;
  logic signed [POS_W-1:0] w_pos_move;
  logic signed [VEL_W-1:0] w_vel_move;
  logic                    w_start;
  logic                    w_frame_tick;
  logic                    w_done;
  logic                    w_visible;

  assign w_right      = RightMove & ~LeftMove;
  assign w_left       = LeftMove & ~RightMove;
  assign w_start      = hitPulse & (r_state == ST_ACTIVE);
  assign w_frame_tick = startOfFrame & (r_state == ST_HIT);

`ifdef SHIP_MOVE_INERTIA_EN
  localparam logic signed [VEL_W:0] MAX_V     = (VEL_W + 1)'(MAX_SPEED);
  localparam logic signed [VEL_W:0] ACC_V     = (VEL_W + 1)'(ACCEL);
  localparam logic signed [VEL_W:0] NEG_ACC_V = (VEL_W + 1)'(-ACCEL);

  logic signed [VEL_W:0] w_vel_ext;
  assign w_vel_ext = {r_vel[VEL_W-1], r_vel};

  // Ramp velocity toward the key direction, or bleed it toward zero without overshooting.
  always_comb begin
    w_vel_next = r_vel;
    if (w_right) begin
      w_vel_next = sat_vel(w_vel_ext + ACC_V, MAX_V);
    end else if (w_left) begin
      w_vel_next = sat_vel(w_vel_ext - ACC_V, MAX_V);
    end else if (w_vel_ext > ACC_V) begin
      w_vel_next = sat_vel(w_vel_ext - ACC_V, MAX_V);
    end else if (w_vel_ext < NEG_ACC_V) begin
      w_vel_next = sat_vel(w_vel_ext + ACC_V, MAX_V);
    end else begin
      w_vel_next = {VEL_W{1'b0}};
    end
  end
`else
  localparam logic signed [VEL_W-1:0] VEL_MAX = VEL_W'(MAX_SPEED);
  localparam logic signed [VEL_W-1:0] VEL_MIN = VEL_W'(-MAX_SPEED);

  // Instant start/stop: full speed in the key direction, zero otherwise.
  always_comb begin
    w_vel_next = {VEL_W{1'b0}};
    if (w_right) begin
      w_vel_next = VEL_MAX;
    end else if (w_left) begin
      w_vel_next = VEL_MIN;
    end else begin
      w_vel_next = {VEL_W{1'b0}};
    end
  end
`endif

  // Candidate position for this frame, pinned to the screen edges; hitting an edge kills velocity.
  always_comb begin
    w_pos_sum  = r_pos + {{(POS_W - VEL_W){w_vel_next[VEL_W-1]}}, w_vel_next};
    w_pos_move = w_pos_sum;
    w_vel_move = w_vel_next;
    if (w_pos_sum > RIGHT_POS) begin
      w_pos_move = RIGHT_POS;
      w_vel_move = {VEL_W{1'b0}};
    end else if (w_pos_sum < LEFT_POS) begin
      w_pos_move = LEFT_POS;
      w_vel_move = {VEL_W{1'b0}};
    end else begin
      w_pos_move = w_pos_sum;
      w_vel_move = w_vel_next;
    end
  end

  hit_blink_timer u_hit_blink_timer (
    .clk       (clk),
    .resetN    (resetN),
    .start     (w_start),
    .frameTick (w_frame_tick),
    .done      (w_done),
    .visible   (w_visible)
  );

  // Ship FSM: frame motion while active, frozen while hit, respawn at the start position.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state      <= ST_ACTIVE;
      r_pos        <= INIT_POS;
      r_vel        <= {VEL_W{1'b0}};
      r_top_left_x <= INIT_X_PIX;
      r_top_left_y <= INIT_Y_PIX;
      r_in_hit     <= 1'b0;
    end else begin
      r_top_left_y <= INIT_Y_PIX;
      case (r_state)
        ST_ACTIVE: begin
          // A hit pre-empts any motion scheduled for the same cycle.
          if (hitPulse) begin
            r_state  <= ST_HIT;
            r_vel    <= {VEL_W{1'b0}};
            r_in_hit <= 1'b1;
          end else if (startOfFrame) begin
            r_pos        <= w_pos_move;
            r_vel        <= w_vel_move;
            r_top_left_x <= w_pos_move[FRAC_BITS +: 11];
          end
        end
        ST_HIT: begin
          if (w_done) begin
            r_state      <= ST_ACTIVE;
            r_pos        <= INIT_POS;
            r_vel        <= {VEL_W{1'b0}};
            r_top_left_x <= INIT_X_PIX;
            r_in_hit     <= 1'b0;
          end
        end
        default: begin
          r_state      <= ST_ACTIVE;
          r_pos        <= INIT_POS;
          r_vel        <= {VEL_W{1'b0}};
          r_top_left_x <= INIT_X_PIX;
          r_in_hit     <= 1'b0;
        end
      endcase
    end
  end

  assign topLeftX  = r_top_left_x;
  assign topLeftY  = r_top_left_y;
  assign velocityX = r_vel;
  assign inHit     = r_in_hit;
  assign visible   = w_visible;

endmodule

// File: tb/tb_ship_move_ctrl.sv
// Self-checking bench for ship_move_ctrl: directed vector table, corner sequences and
// randomized traffic against a frame-level reference model (follows SHIP_MOVE_INERTIA_EN).
module tb_ship_move_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               resetN;
  logic               sof;
  logic               rm;
  logic               lm;
  logic               hit;
  logic signed [10:0] tlx;
  logic signed [10:0] tly;
  logic signed [11:0] vx;
  logic               inh;
  logic               vis;

  ship_move_ctrl dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (sof),
    .RightMove    (rm),
    .LeftMove     (lm),
    .hitPulse     (hit),
    .topLeftX     (tlx),
    .topLeftY     (tly),
    .velocityX    (vx),
    .inHit        (inh),
    .visible      (vis)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state: position in 1/64 px, velocity, hit status, frames spent in hit.
  int m_pos;
  int m_vel;
  int m_hit_frames;
  bit m_hit;
  bit m_vis;

  typedef struct {
    bit s;
    bit r;
    bit l;
    bit h;
    int x;
    int v;
    bit ih;
    bit vs;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos        = 280 * 64;
    m_vel        = 0;
    m_hit        = 1'b0;
    m_vis        = 1'b1;
    m_hit_frames = 0;
  endtask

  task automatic model_step(input bit s, input bit r, input bit l, input bit h);
    int dir;
    int v;
    int p;
    if (!m_hit) begin
      if (h) begin
        m_hit        = 1'b1;
        m_vel        = 0;
        m_hit_frames = 0;
        m_vis        = 1'b0;
      end else if (s) begin
        dir = (r && !l) ? 1 : ((l && !r) ? -1 : 0);
`ifdef SHIP_MOVE_INERTIA_EN
        if (dir != 0) begin
          v = m_vel + dir * 48;
          if (v > 192)  v = 192;
          if (v < -192) v = -192;
        end else if (m_vel > 48) begin
          v = m_vel - 48;
        end else if (m_vel < -48) begin
          v = m_vel + 48;
        end else begin
          v = 0;
        end
`else
        v = dir * 192;
`endif
        p = m_pos + v;
        if (p > 570 * 64) begin
          p = 570 * 64;
          v = 0;
        end else if (p < 5 * 64) begin
          p = 5 * 64;
          v = 0;
        end
        m_pos = p;
        m_vel = v;
      end
    end else if (s) begin
      m_hit_frames++;
      if (m_hit_frames >= 60) begin
        model_reset();
      end else begin
        m_vis = ((m_hit_frames / 4) % 2) == 1;
      end
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_x"},   int'(tlx), m_pos >>> 6);
    chk({tag, "_y"},   int'(tly), 400);
    chk({tag, "_vel"}, int'(vx),  m_vel);
    chk({tag, "_hit"}, int'(inh), int'(m_hit));
    chk({tag, "_vis"}, int'(vis), int'(m_vis));
  endtask

  task automatic cycle(input bit s, input bit r, input bit l, input bit h, input string tag);
    sof = s; rm = r; lm = l; hit = h;
    @(posedge clk);
    model_step(s, r, l, h);
    #1;
    sof = 1'b0;
    hit = 1'b0;
    chk_model(tag);
  endtask

  task automatic frame(input bit r, input bit l, input string tag);
    cycle(1'b1, r, l, 1'b0, tag);
    cycle(1'b0, r, l, 1'b0, tag);
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    sof = 1'b0; rm = 1'b0; lm = 1'b0; hit = 1'b0;
    #2;
    model_reset();
    chk_model("reset");
    @(posedge clk);
    #1;
    resetN = 1'b1;
  endtask

  initial begin
    int x_before;
    int n;
    bit s, r, l, h;

    resetN = 1'b1;
    sof = 1'b0; rm = 1'b0; lm = 1'b0; hit = 1'b0;
    model_reset();

`ifdef SHIP_MOVE_INERTIA_EN
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 280,  48, 1'b0, 1'b1};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 282,  96, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 284, 144, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 287, 192, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 290, 192, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 292, 144, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 292,   0, 1'b1, 1'b0};
`else
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 283,  192, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 283,  192, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 283,    0, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 280, -192, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 280,    0, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 280,    0, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 280,    0, 1'b1, 1'b0};
`endif

    #1;
    do_reset();
    chk("rst_x",   int'(tlx), 280);
    chk("rst_y",   int'(tly), 400);
    chk("rst_vel", int'(vx),  0);
    chk("rst_hit", int'(inh), 0);
    chk("rst_vis", int'(vis), 1);

    // Directed vector table.
    for (int i = 0; i < 7; i++) begin
      sof = tbl[i].s; rm = tbl[i].r; lm = tbl[i].l; hit = tbl[i].h;
      @(posedge clk);
      model_step(tbl[i].s, tbl[i].r, tbl[i].l, tbl[i].h);
      #1;
      sof = 1'b0; hit = 1'b0;
      chk($sformatf("tbl%0d_x", i),   int'(tlx), tbl[i].x);
      chk($sformatf("tbl%0d_vel", i), int'(vx),  tbl[i].v);
      chk($sformatf("tbl%0d_hit", i), int'(inh), int'(tbl[i].ih));
      chk($sformatf("tbl%0d_vis", i), int'(vis), int'(tbl[i].vs));
    end

    // Left clamp, then both keys held keeps the ship still.
    do_reset();
    for (int i = 0; i < 200; i++) frame(1'b0, 1'b1, "left");
    chk("left_clamp_x",   int'(tlx), 5);
    chk("left_clamp_vel", int'(vx),  0);
    for (int i = 0; i < 5; i++) frame(1'b1, 1'b1, "both");
    chk("both_frozen_x", int'(tlx), 5);

    // Right clamp.
    for (int i = 0; i < 250; i++) frame(1'b1, 1'b0, "right");
    chk("right_clamp_x",   int'(tlx), 570);
    chk("right_clamp_vel", int'(vx),  0);

    // Hit window with blink, an ignored second hit and respawn.
    do_reset();
    n = 0;
    while ((m_pos >>> 6) < 300 && n < 100) begin
      frame(1'b1, 1'b0, "to300");
      n++;
    end
    x_before = int'(tlx);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, "hit_enter");
    chk("hit_enter_inh", int'(inh), 1);
    chk("hit_enter_vis", int'(vis), 0);
    chk("hit_enter_x",   int'(tlx), x_before);
    for (int i = 0; i < 60; i++) begin
      frame(1'b1, 1'b0, "hitwin");
      if (i == 3)  chk("blink_on_4",  int'(vis), 1);
      if (i == 7)  chk("blink_off_8", int'(vis), 0);
      if (i == 29) cycle(1'b0, 1'b0, 1'b0, 1'b1, "hit2_ignored");
      if (i == 58) chk("still_hit_59", int'(inh), 1);
      if (i < 59)  chk("hit_frozen_x", int'(tlx), x_before);
    end
    chk("respawn_x",   int'(tlx), 280);
    chk("respawn_inh", int'(inh), 0);
    chk("respawn_vis", int'(vis), 1);
    chk("respawn_vel", int'(vx),  0);

    // Hit coincident with start of frame while Right held.
    do_reset();
    frame(1'b1, 1'b0, "pre_coinc");
    frame(1'b1, 1'b0, "pre_coinc");
    x_before = int'(tlx);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, "coinc");
    chk("coinc_x",   int'(tlx), x_before);
    chk("coinc_inh", int'(inh), 1);
    chk("coinc_vel", int'(vx),  0);

    // Asynchronous reset in the middle of a hit window.
    do_reset();
    frame(1'b1, 1'b0, "pre_hit_rst");
    cycle(1'b0, 1'b0, 1'b0, 1'b1, "hit_rst_enter");
    for (int i = 0; i < 20; i++) frame(1'b0, 1'b0, "hit_rst_win");
    resetN = 1'b0;
    #2;
    chk("async_rst_x",   int'(tlx), 280);
    chk("async_rst_inh", int'(inh), 0);
    chk("async_rst_vis", int'(vis), 1);
    chk("async_rst_vel", int'(vx),  0);
    model_reset();
    @(posedge clk);
    #1;
    resetN = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 999) == 0) begin
        do_reset();
      end else begin
        s = ($urandom_range(0, 3) == 0);
        r = 1'($urandom_range(0, 1));
        l = 1'($urandom_range(0, 1));
        h = ($urandom_range(0, 149) == 0);
        cycle(s, r, l, h, "rand");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
